// File: rtl/regfile_sb_if.sv
// Register file access bundle: two read ports, writeback, issue and flush.
// The master modport drives addresses and commands; the slave returns data and busy state.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic [CW-1:0]   busy_cnt;

    modport master (
        output a1, a2, we3, a3, wd3, iss_en, iss_rd, flush,
        input  rd1, rd2, busy1, busy2, busy_cnt
    );

    modport slave (
        input  a1, a2, we3, a3, wd3, iss_en, iss_rd, flush,
        output rd1, rd2, busy1, busy2, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with optional writeback bypass
// and a per-register busy scoreboard; register 0 reads as zero.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst_n,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic            wr_en;
    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] rd1_v;
    logic [XLEN-1:0] rd2_v;

    assign wr_en = bus.we3 && (bus.a3 != '0);
    assign hit1  = (BYPASS != 0) && bus.we3 && (bus.a3 == bus.a1);
    assign hit2  = (BYPASS != 0) && bus.we3 && (bus.a3 == bus.a2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[bus.a3] <= bus.wd3;
        end
    end

    // Issue is applied after writeback so a new producer supersedes a completing one.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (bus.we3) begin
                busy_d[bus.a3] = 1'b0;
            end
            if (bus.iss_en) begin
                busy_d[bus.iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d = cnt_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd1_v = rf_q[bus.a1];
        if (bus.a1 == AW'(0)) begin
            rd1_v = '0;
        end else if (hit1) begin
            rd1_v = bus.wd3;
        end
    end

    always_comb begin
        rd2_v = rf_q[bus.a2];
        if (bus.a2 == AW'(0)) begin
            rd2_v = '0;
        end else if (hit2) begin
            rd2_v = bus.wd3;
        end
    end

    assign bus.rd1      = rd1_v;
    assign bus.rd2      = rd2_v;
    assign bus.busy1    = busy_q[bus.a1] && !hit1;
    assign bus.busy2    = busy_q[bus.a2] && !hit2;
    assign bus.busy_cnt = cnt_q;
endmodule
